// File: rtl/any1_pkg.sv
// rtl/any1_pkg.sv - shared fetch/align types and constants
package any1_pkg;

   localparam int AWID          = 32;
   localparam int LINEW         = 512;
   localparam int LINE_OFS_BITS = 6;
   localparam int IP_INC        = 4;

   // Fetch-side bundle handed to the aligner
   typedef struct packed {
      logic [LINEW-1:0] cacheline;
      logic [AWID-1:0]  ip;
      logic [AWID-1:0]  pip;
      logic             predict_taken;
   } sInstAlignIn;

   // Aligned instruction handed to decode
   typedef struct packed {
      logic [31:0]     ir;
      logic [AWID-1:0] ip;
      logic            predict_taken;
   } sInstAlignOut;

   typedef enum logic [1:0] {
      S_RESET,
      S_RUN,
      S_MISS,
      S_FAULT
   } eIfetchState;

endpackage

// File: rtl/any1_ialign.sv
// rtl/any1_ialign.sv - picks the 32-bit word at ip out of the fetched line
module any1_ialign
   import any1_pkg::*;
(
   input  sInstAlignIn  inst_i,
   output sInstAlignOut inst_o
);

   logic [8:0] bit_ofs;

   // Word select by line offset; misaligned ips are reported downstream, not here
   always_comb begin
      bit_ofs              = {inst_i.ip[5:2], 5'b0};
      inst_o.ir            = inst_i.cacheline[bit_ofs +: 32];
      inst_o.ip            = inst_i.ip;
      inst_o.predict_taken = inst_i.predict_taken;
   end

endmodule

// File: rtl/any1_ifetch_seq.sv
// rtl/any1_ifetch_seq.sv - instruction fetch sequencer with single-line buffer
module any1_ifetch_seq
   import any1_pkg::*;
#(
   parameter logic [AWID-1:0] RSTIP = 32'hFFFC0100
)
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             redirect_i,
   input  logic [AWID-1:0]  redirect_ip_i,
   input  logic             bp_taken_i,
   input  logic [AWID-1:0]  bp_target_i,
   output logic             ic_req_o,
   output logic [AWID-1:0]  ic_adr_o,
   input  logic             ic_ack_i,
   input  logic [LINEW-1:0] ic_line_i,
   input  logic             ic_err_i,
   output sInstAlignIn      al_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic             fetch_fault_o
);

   localparam int TAGW = AWID - LINE_OFS_BITS;

   eIfetchState      state;
   logic [AWID-1:0]  ip;
   logic [AWID-1:0]  pip;
   logic [LINEW-1:0] line_buf;
   logic [TAGW-1:0]  buf_tag;
   logic             buf_valid;
   logic             drop_pending;
   logic             hit;
   logic             line_load;

   // Line hit and decode handshake qualifier
   always_comb begin
      hit         = buf_valid && (buf_tag == ip[AWID-1:LINE_OFS_BITS]);
      out_valid_o = (state == S_RUN) && hit;
      line_load   = (state == S_MISS) && ic_ack_i && !ic_err_i && !redirect_i;
   end

   // Aligner bundle; the prediction only means something alongside a valid instruction
   always_comb begin
      al_o.cacheline     = line_buf;
      al_o.ip            = ip;
      al_o.pip           = pip;
      al_o.predict_taken = out_valid_o & bp_taken_i;
   end

   // Line data register, captured on a clean, non-redirected ack
   always_ff @(posedge clk_i) begin
      if (line_load)
         line_buf <= ic_line_i;
   end

   // Fetch state machine: ip advance, miss handling, redirects and faults
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= S_RESET;
         ip            <= RSTIP;
         pip           <= RSTIP;
         buf_valid     <= 1'b0;
         buf_tag       <= '0;
         ic_req_o      <= 1'b0;
         ic_adr_o      <= '0;
         fetch_fault_o <= 1'b0;
         drop_pending  <= 1'b0;
      end else begin
         fetch_fault_o <= 1'b0;
         // An ack for an abandoned request only retires the drop flag
         if (drop_pending && ic_ack_i)
            drop_pending <= 1'b0;
         if (redirect_i) begin
            // Redirect beats any same-cycle transfer or returning line
            ip       <= redirect_ip_i;
            pip      <= ip;
            state    <= S_RUN;
            ic_req_o <= 1'b0;
            if (state == S_MISS && !ic_ack_i)
               drop_pending <= 1'b1;
         end else begin
            case (state)
               S_RESET: begin
                  state <= S_RUN;
               end
               S_RUN: begin
                  if (hit) begin
                     if (out_ready_i) begin
                        pip <= ip;
                        ip  <= bp_taken_i ? bp_target_i : ip + AWID'(IP_INC);
                     end
                  end else if (!drop_pending) begin
                     ic_req_o <= 1'b1;
                     ic_adr_o <= {ip[AWID-1:LINE_OFS_BITS], {LINE_OFS_BITS{1'b0}}};
                     state    <= S_MISS;
                  end
               end
               S_MISS: begin
                  if (ic_ack_i) begin
                     ic_req_o <= 1'b0;
                     if (ic_err_i) begin
                        buf_valid     <= 1'b0;
                        fetch_fault_o <= 1'b1;
                        state         <= S_FAULT;
                     end else begin
                        buf_valid <= 1'b1;
                        buf_tag   <= ic_adr_o[AWID-1:LINE_OFS_BITS];
                        state     <= S_RUN;
                     end
                  end
               end
               S_FAULT: begin
                  state <= S_FAULT;
               end
               default: begin
                  state <= S_RESET;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_any1_ifetch_seq.sv
// tb/tb_any1_ifetch_seq.sv - directed vector bench for any1_ifetch_seq
module tb_any1_ifetch_seq;
   import any1_pkg::*;

   localparam logic [31:0] R = 32'hFFFC0100;

   typedef struct {
      logic        rd;
      logic [31:0] rip;
      logic        bp;
      logic [31:0] bt;
      logic        ack;
      logic        err;
      logic [31:0] seed;
      logic        rdy;
      logic        e_v;
      logic [31:0] e_ip;
      logic [31:0] e_pip;
      logic        e_req;
      logic [31:0] e_adr;
      logic        e_flt;
      logic [31:0] e_ir;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_i = 1'b1;
   logic         redirect_i = 1'b0;
   logic [31:0]  redirect_ip_i = '0;
   logic         bp_taken_i = 1'b0;
   logic [31:0]  bp_target_i = '0;
   logic         ic_req_o;
   logic [31:0]  ic_adr_o;
   logic         ic_ack_i = 1'b0;
   logic [511:0] ic_line_i = '0;
   logic         ic_err_i = 1'b0;
   sInstAlignIn  al_o;
   sInstAlignOut alo;
   logic         out_valid_o;
   logic         out_ready_i = 1'b0;
   logic         fetch_fault_o;

   int   checks = 0;
   int   errors = 0;
   vec_t vq[$];

   any1_ifetch_seq #(.RSTIP(R)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .redirect_i   (redirect_i),
      .redirect_ip_i(redirect_ip_i),
      .bp_taken_i   (bp_taken_i),
      .bp_target_i  (bp_target_i),
      .ic_req_o     (ic_req_o),
      .ic_adr_o     (ic_adr_o),
      .ic_ack_i     (ic_ack_i),
      .ic_line_i    (ic_line_i),
      .ic_err_i     (ic_err_i),
      .al_o         (al_o),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .fetch_fault_o(fetch_fault_o)
   );

   any1_ialign u_align (
      .inst_i(al_o),
      .inst_o(alo)
   );

   always #5 clk = ~clk;

   function automatic logic [511:0] mk_line(input logic [31:0] seed);
      logic [511:0] l;
      for (int k = 0; k < 16; k++)
         l[k*32 +: 32] = seed + 32'(k);
      return l;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic rd, input logic [31:0] rip, input logic bp, input logic [31:0] bt,
                      input logic ack, input logic err, input logic [31:0] seed, input logic rdy,
                      input logic ev, input logic [31:0] eip, input logic [31:0] epip,
                      input logic ereq, input logic [31:0] eadr, input logic eflt, input logic [31:0] eir);
      vec_t v;
      v.rd = rd; v.rip = rip; v.bp = bp; v.bt = bt; v.ack = ack; v.err = err;
      v.seed = seed; v.rdy = rdy; v.e_v = ev; v.e_ip = eip; v.e_pip = epip;
      v.e_req = ereq; v.e_adr = eadr; v.e_flt = eflt; v.e_ir = eir;
      vq.push_back(v);
   endtask

   task automatic idle_inputs();
      redirect_i = 0; redirect_ip_i = '0; bp_taken_i = 0; bp_target_i = '0;
      ic_ack_i = 0; ic_err_i = 0; out_ready_i = 0;
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, ".valid"}, 64'(out_valid_o), 64'd0);
      chk({nm, ".ip"}, 64'(al_o.ip), 64'(R));
      chk({nm, ".pip"}, 64'(al_o.pip), 64'(R));
      chk({nm, ".req"}, 64'(ic_req_o), 64'd0);
      chk({nm, ".adr"}, 64'(ic_adr_o), 64'd0);
      chk({nm, ".fault"}, 64'(fetch_fault_o), 64'd0);
      chk({nm, ".pt"}, 64'(al_o.predict_taken), 64'd0);
   endtask

   initial begin
      // Reset release -> first request, then fill with word k = k
      add(0,0,0,0, 0,0,0,0, 0,R,R,0,0,0,0);
      add(0,0,0,0, 0,0,0,0, 0,R,R,1,R,0,0);
      add(0,0,0,0, 1,0,0,0, 0,R,R,1,R,0,0);
      // Decode stalled five cycles
      for (int k = 0; k < 5; k++)
         add(0,0,0,0, 0,0,0,0, 1,R,R,0,0,0,0);
      // Streaming through the whole line
      for (int k = 0; k < 16; k++)
         add(0,0,0,0, 0,0,0,1, 1, R + 32'(4*k), (k == 0) ? R : R + 32'(4*k - 4), 0,0,0, 32'(k));
      add(0,0,0,0, 0,0,0,0, 0,R+64,R+60,0,0,0,0);
      add(0,0,0,0, 0,0,0,0, 0,R+64,R+60,1,R+64,0,0);
      // Error ack -> fault pulse, then stuck without valid even with ready high
      add(0,0,0,0, 1,1,0,0, 0,R+64,R+60,1,R+64,0,0);
      add(0,0,0,0, 0,0,0,1, 0,R+64,R+60,0,0,1,0);
      for (int k = 0; k < 5; k++)
         add(0,0,0,0, 0,0,0,1, 0,R+64,R+60,0,0,0,0);
      add(1,32'hFFFC0000,0,0, 0,0,0,0, 0,R+64,R+60,0,0,0,0);
      add(0,0,0,0, 0,0,0,0, 0,32'hFFFC0000,R+64,0,0,0,0);
      add(0,0,0,0, 0,0,0,0, 0,32'hFFFC0000,R+64,1,32'hFFFC0000,0,0);
      add(0,0,0,0, 1,0,32'h100,0, 0,32'hFFFC0000,R+64,1,32'hFFFC0000,0,0);
      // Redirect with ready high: transfer dropped
      add(1,32'h1000,0,0, 0,0,0,1, 1,32'hFFFC0000,R+64,0,0,0,32'h100);
      add(0,0,0,0, 0,0,0,0, 0,32'h1000,32'hFFFC0000,0,0,0,0);
      add(0,0,0,0, 0,0,0,0, 0,32'h1000,32'hFFFC0000,1,32'h1000,0,0);
      add(0,0,0,0, 1,0,32'h200,0, 0,32'h1000,32'hFFFC0000,1,32'h1000,0,0);
      // Predicted taken inside the line, then to another line
      add(0,0,1,32'h1020, 0,0,0,1, 1,32'h1000,32'hFFFC0000,0,0,0,32'h200);
      add(0,0,1,32'h2000, 0,0,0,1, 1,32'h1020,32'h1000,0,0,0,32'h208);
      add(0,0,0,0, 0,0,0,0, 0,32'h2000,32'h1020,0,0,0,0);
      add(0,0,0,0, 1,0,32'h300,0, 0,32'h2000,32'h1020,1,32'h2000,0,0);
      // Redirect away from an outstanding miss, stale ack three cycles later
      add(1,32'h1040,0,0, 0,0,0,0, 1,32'h2000,32'h1020,0,0,0,32'h300);
      add(0,0,0,0, 0,0,0,0, 0,32'h1040,32'h2000,0,0,0,0);
      add(1,32'h3008,0,0, 0,0,0,0, 0,32'h1040,32'h2000,1,32'h1040,0,0);
      add(0,0,0,0, 0,0,0,0, 0,32'h3008,32'h1040,0,0,0,0);
      add(0,0,0,0, 0,0,0,0, 0,32'h3008,32'h1040,0,0,0,0);
      add(0,0,0,0, 1,0,32'h999,0, 0,32'h3008,32'h1040,0,0,0,0);
      add(0,0,0,0, 0,0,0,0, 0,32'h3008,32'h1040,0,0,0,0);
      add(0,0,0,0, 0,0,0,0, 0,32'h3008,32'h1040,1,32'h3000,0,0);
      add(0,0,0,0, 1,0,32'h400,0, 0,32'h3008,32'h1040,1,32'h3000,0,0);
      // Redirect within the buffered line: no request
      add(1,32'h3030,0,0, 0,0,0,0, 1,32'h3008,32'h1040,0,0,0,32'h402);
      add(1,32'h5000,0,0, 0,0,0,0, 1,32'h3030,32'h3008,0,0,0,32'h40C);
      add(0,0,0,0, 0,0,0,0, 0,32'h5000,32'h3030,0,0,0,0);
      // Redirect and ack together: line discarded, no drop pending
      add(1,32'h5010,0,0, 1,0,32'h777,0, 0,32'h5000,32'h3030,1,32'h5000,0,0);
      add(0,0,0,0, 0,0,0,0, 0,32'h5010,32'h5000,0,0,0,0);
      add(0,0,0,0, 0,0,0,0, 0,32'h5010,32'h5000,1,32'h5000,0,0);
      add(0,0,0,0, 1,0,32'h500,0, 0,32'h5010,32'h5000,1,32'h5000,0,0);
      add(0,0,0,0, 0,0,0,0, 1,32'h5010,32'h5000,0,0,0,32'h504);

      idle_inputs();
      rst_i = 1;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk_reset("reset");
      rst_i = 0;

      foreach (vq[i]) begin
         @(negedge clk);
         redirect_i = vq[i].rd; redirect_ip_i = vq[i].rip;
         bp_taken_i = vq[i].bp; bp_target_i = vq[i].bt;
         ic_ack_i = vq[i].ack; ic_err_i = vq[i].err;
         ic_line_i = mk_line(vq[i].seed); out_ready_i = vq[i].rdy;
         #1;
         chk($sformatf("v%0d.valid", i), 64'(out_valid_o), 64'(vq[i].e_v));
         chk($sformatf("v%0d.ip", i), 64'(al_o.ip), 64'(vq[i].e_ip));
         chk($sformatf("v%0d.pip", i), 64'(al_o.pip), 64'(vq[i].e_pip));
         chk($sformatf("v%0d.req", i), 64'(ic_req_o), 64'(vq[i].e_req));
         chk($sformatf("v%0d.fault", i), 64'(fetch_fault_o), 64'(vq[i].e_flt));
         if (vq[i].e_req)
            chk($sformatf("v%0d.adr", i), 64'(ic_adr_o), 64'(vq[i].e_adr));
         if (vq[i].e_v) begin
            chk($sformatf("v%0d.ir", i), 64'(alo.ir), 64'(vq[i].e_ir));
            chk($sformatf("v%0d.pt", i), 64'(al_o.predict_taken), 64'(vq[i].bp));
         end
      end

      // Reset in the middle of a miss
      @(negedge clk);
      idle_inputs();
      redirect_i = 1; redirect_ip_i = 32'h7000;
      @(negedge clk);
      idle_inputs();
      @(negedge clk); #1;
      chk("midmiss.req", 64'(ic_req_o), 64'd1);
      chk("midmiss.adr", 64'(ic_adr_o), 64'h7000);
      rst_i = 1;
      @(negedge clk); #1;
      chk_reset("midmiss_rst");
      rst_i = 0;
      @(negedge clk);
      @(negedge clk); #1;
      chk("rerun.req", 64'(ic_req_o), 64'd1);
      chk("rerun.adr", 64'(ic_adr_o), 64'(R));
      chk("rerun.valid", 64'(out_valid_o), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
